// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink interface (generator and monitor sides).
package blink_pkg;

   // Default half-period counter width; the blink generator uses the same value.
   localparam int BLINK_CBITS = 28;

   // Monitor lock-acquisition states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_MEASURE,
      S_TRACK,
      S_LOCKED,
      S_STUCK
   } state_t;

endpackage

// File: rtl/blink_edge_sync.sv
// Brings the asynchronous blink line into the clk domain and produces a
// registered one-cycle pulse for every transition of the synchronised line.
module blink_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic led_in,
   output logic edge_pulse
);

   logic sync1;
   logic sync2;
   logic hist;

   // Two-flop synchroniser, history flop and registered transition pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         hist       <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync1      <= led_in;
         sync2      <= sync1;
         hist       <= sync2;
         edge_pulse <= sync2 ^ hist;
      end
   end

endmodule

// File: rtl/blink_monitor.sv
// Receive side of the LED blink interface: measures the half-period of the
// blink line, declares lock once it is stable and flags a stuck line.
module blink_monitor
   import blink_pkg::*;
#(
   parameter int CBITS  = BLINK_CBITS,
   parameter int TOL    = 4,
   parameter int LOCK_N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             led_in,
   output logic             edge_pulse,
   output logic             locked,
   output logic             stuck,
   output logic [CBITS-1:0] half_period
);

   localparam logic [CBITS-1:0] CMAX = {CBITS{1'b1}};

   state_t           state_reg,  state_next;
   logic [CBITS-1:0] cnt_reg,    cnt_next;
   logic [CBITS-1:0] ref_reg,    ref_next;
   logic [3:0]       mcnt_reg,   mcnt_next;
   logic             locked_reg, locked_next;
   logic             stuck_reg,  stuck_next;

   logic [CBITS-1:0] diff;
   logic             match;
   logic             timeout;

   blink_edge_sync u_edge_sync (
      .clk        (clk),
      .rst        (rst),
      .led_in     (led_in),
      .edge_pulse (edge_pulse)
   );

   // Measured length is the counter value in the edge cycle; compare it with
   // the reference without wrapping, and detect saturation without an edge.
   always_comb begin
      diff    = (cnt_reg >= ref_reg) ? (cnt_reg - ref_reg) : (ref_reg - cnt_reg);
      match   = (diff <= CBITS'(TOL));
      timeout = !edge_pulse && (cnt_reg == CMAX);
   end

   // Next-state logic: counter, reference, match count and lock FSM.
   always_comb begin
      state_next = state_reg;
      ref_next   = ref_reg;
      mcnt_next  = mcnt_reg;

      if (edge_pulse)
         cnt_next = CBITS'(1);
      else if (cnt_reg == CMAX)
         cnt_next = cnt_reg;
      else
         cnt_next = cnt_reg + CBITS'(1);

      // An edge in the saturation cycle suppresses the timeout (timeout needs !edge).
      if (timeout && state_reg != S_STUCK) begin
         state_next = S_STUCK;
         mcnt_next  = 4'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (edge_pulse) state_next = S_MEASURE;
            end
            S_MEASURE: begin
               if (edge_pulse) begin
                  ref_next   = cnt_reg;
                  mcnt_next  = 4'd0;
                  state_next = S_TRACK;
               end
            end
            S_TRACK: begin
               if (edge_pulse) begin
                  if (match) begin
                     mcnt_next = mcnt_reg + 4'd1;
                     if (mcnt_next == 4'(LOCK_N)) state_next = S_LOCKED;
                  end else begin
                     ref_next  = cnt_reg;
                     mcnt_next = 4'd0;
                  end
               end
            end
            S_LOCKED: begin
               // Matching levels leave the reference alone: no drift tracking.
               if (edge_pulse && !match) begin
                  ref_next   = cnt_reg;
                  mcnt_next  = 4'd0;
                  state_next = S_TRACK;
               end
            end
            S_STUCK: begin
               if (edge_pulse) state_next = S_MEASURE;
            end
            default: state_next = S_IDLE;
         endcase
      end

      locked_next = (state_next == S_LOCKED);
      stuck_next  = (state_next == S_STUCK);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         ref_reg    <= '0;
         mcnt_reg   <= 4'd0;
         locked_reg <= 1'b0;
         stuck_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ref_reg    <= ref_next;
         mcnt_reg   <= mcnt_next;
         locked_reg <= locked_next;
         stuck_reg  <= stuck_next;
      end
   end

   assign locked      = locked_reg;
   assign stuck       = stuck_reg;
   assign half_period = ref_reg;

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor: stimulus is a sequence of level lengths,
// expectations come from a level-based lock model.
module tb_blink_monitor;

   localparam int CB    = 6;
   localparam int TOLV  = 4;
   localparam int LN    = 3;
   localparam int CMAXV = 63;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          led_in = 1'b0;
   logic          edge_pulse;
   logic          locked;
   logic          stuck;
   logic [CB-1:0] half_period;

   typedef struct {
      bit lk;
      int hp;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   since = 0;
   bit   pending = 0;

   // Level-based model: 0 = no edge yet, 1 = first edge seen, 2 = tracking, 3 = locked.
   int   m_phase = 0;
   int   m_ref = 0;
   int   m_mcnt = 0;

   blink_monitor #(.CBITS(CB), .TOL(TOLV), .LOCK_N(LN)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .led_in      (led_in),
      .edge_pulse  (edge_pulse),
      .locked      (locked),
      .stuck       (stuck),
      .half_period (half_period)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Apply one transition that ends a level of 'gap' cycles.
   task automatic model_edge(input int gap);
      exp_t e;
      int   d;
      if (gap > CMAXV) begin
         // Line was declared stuck during the level; this edge restarts measuring.
         m_phase = 1;
         m_mcnt  = 0;
      end else begin
         d = (gap > m_ref) ? gap - m_ref : m_ref - gap;
         case (m_phase)
            0: m_phase = 1;
            1: begin m_ref = gap; m_mcnt = 0; m_phase = 2; end
            2: begin
               if (d <= TOLV) begin
                  m_mcnt++;
                  if (m_mcnt == LN) m_phase = 3;
               end else begin
                  m_ref = gap; m_mcnt = 0;
               end
            end
            default: begin
               if (d > TOLV) begin m_ref = gap; m_mcnt = 0; m_phase = 2; end
            end
         endcase
      end
      e.lk = (m_phase == 3);
      e.hp = m_ref;
      q.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      since++;
   endtask

   task automatic toggle();
      led_in = ~led_in;
      model_edge(since);
      since = 0;
   endtask

   task automatic level(input int n);
      repeat (n) tick();
      toggle();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_edge"}, int'(edge_pulse), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_stuck"}, int'(stuck), 0);
      check({tag, "_hp"}, int'(half_period), 0);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero(tag);
      led_in = 1'b0;
      q.delete();
      m_phase = 0; m_ref = 0; m_mcnt = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      since = 0;
   endtask

   // Monitor: one cycle after every edge pulse, compare the registered outputs.
   always @(negedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else begin
         if (pending) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL edge_unexpected: got edge with empty queue, expected none");
            end else begin
               exp_t e;
               e = q.pop_front();
               check("locked", int'(locked), int'(e.lk));
               check("stuck", int'(stuck), 0);
               if (e.lk) check("half_period", int'(half_period), e.hp);
               $display("edge: locked=%0d stuck=%0d hp=%0d exp_locked=%0d exp_hp=%0d",
                        locked, stuck, half_period, e.lk, e.hp);
            end
         end
         pending <= edge_pulse;
         check("never_both", int'(locked && stuck), 0);
      end
   end

   initial begin
      int i;
      int base;
      int len;

      // Reset state.
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      since = 0;

      // Square wave of 10: lock after fifth edge.
      repeat (5) level(10);
      repeat (5) tick();
      check("lock10_locked", int'(locked), 1);
      check("lock10_hp", int'(half_period), 10);

      // Alternating 10/12 stays locked; 15 breaks lock; three more 15 relock.
      repeat (3) begin level(10); level(12); end
      level(15);
      repeat (3) level(15);
      // Tolerance boundary around 15: 19 and 11 match, 20 does not.
      level(19); level(11); level(20);
      repeat (3) level(20);
      repeat (6) tick();
      check("lock20_locked", int'(locked), 1);

      // Freeze the line while locked: locked drops exactly when stuck rises.
      for (i = 0; i < 120; i++) begin
         tick();
         if (!locked) break;
      end
      check("frozen_locked", int'(locked), 0);
      check("frozen_stuck", int'(stuck), 1);
      toggle();
      repeat (4) level(10);
      repeat (5) tick();
      check("relock_locked", int'(locked), 1);

      // Reset while locked clears everything; five fresh edges relock.
      do_reset("midrst");
      repeat (5) level(10);
      repeat (5) tick();
      check("postrst_locked", int'(locked), 1);
      check("postrst_hp", int'(half_period), 10);

      // Line never toggles after reset: stuck, then recovery on first toggle.
      do_reset("rst2");
      repeat (100) tick();
      check("idle_stuck", int'(stuck), 1);
      check("idle_locked", int'(locked), 0);
      toggle();

      // Randomised levels: mostly near a base period, sometimes arbitrary.
      base = int'($urandom_range(8, 25));
      for (i = 0; i < 80; i++) begin
         if ($urandom_range(0, 15) == 0) base = int'($urandom_range(8, 25));
         if ($urandom_range(0, 3) != 0)
            len = base + int'($urandom_range(0, 10)) - 5;
         else
            len = int'($urandom_range(3, 40));
         level(len);
      end

      // Drain outstanding expectations.
      repeat (8) tick();
      check("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
